cmd_alu_engine: RTL and testbench

Command-driven arithmetic state machine with a local register file. It accepts one opcode per valid/ready handshake, executes READ/WRITE/ADD/SUB/CLR against a parametrised 2^ADDR_W x DATA_W array, and returns the result with carry/borrow and error flags through a valid/ready response port. It is the parametrised successor of the team's fixed-width case-decoded opcode and READ/WRITE blocks, and sits between a command master and downstream result consumers.

---
 rtl/cmd_alu_pkg.sv | 22 ++
 rtl/cmd_alu_regfile.sv | 38 +++
 rtl/cmd_alu_engine.sv | 147 ++++++++++++++
 tb/tb_cmd_alu_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_alu_pkg.sv
// Shared opcode/state encodings and constants for the command-driven ALU engine.
package cmd_alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_READ  = 3'd1,
    OP_WRITE = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_CLR   = 3'd5
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_INIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int unsigned ILLEGAL_RSP_DATA = 0;

endpackage

// File: rtl/cmd_alu_regfile.sv
// DEPTH x DATA_W flop array: async clear, one write port, one combinational
// read port and a single-entry clear port used by the engine's INIT sweep.
module cmd_alu_regfile
  import cmd_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Clear-entry takes priority; the engine never asserts both in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_clr && (i_clr_addr == ADDR_W'(i))) r_mem[i] <= '0;
        else if (i_we && (i_waddr == ADDR_W'(i))) r_mem[i] <= i_wdata;
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cmd_alu_engine.sv
// Command-driven READ/WRITE/ADD/SUB/CLR engine over a local register file.
// Define CMD_ALU_SAT_EN to make ADD saturate and SUB clamp instead of wrapping.
module cmd_alu_engine
  import cmd_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_flag,
  output logic              rsp_err,
  output logic              busy
);

  state_e            r_state;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_sweep;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_flag;
  logic              r_rsp_err;

  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_result;
  logic              w_flag;
  logic              w_err;
  logic              w_we;

  cmd_alu_regfile #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we && (r_state == ST_EXEC)),
    .i_waddr   (r_addr),
    .i_wdata   (w_result),
    .i_clr     (r_state == ST_INIT),
    .i_clr_addr(r_sweep),
    .i_raddr   (r_addr),
    .o_rdata   (w_rdata)
  );

  // Top bit of the widened sum/difference is the carry/borrow.
  assign w_sum  = {1'b0, w_rdata} + {1'b0, r_data};
  assign w_diff = {1'b0, w_rdata} - {1'b0, r_data};

  always_comb begin
    w_result = '0;
    w_flag   = 1'b0;
    w_err    = 1'b0;
    w_we     = 1'b0;
    case (r_op)
      OP_NOP:  w_result = '0;
      OP_READ: w_result = w_rdata;
      OP_WRITE: begin
        w_result = r_data;
        w_we     = 1'b1;
      end
      OP_ADD: begin
        w_flag   = w_sum[DATA_W];
        w_result = w_sum[DATA_W-1:0];
`ifdef CMD_ALU_SAT_EN
        if (w_sum[DATA_W]) w_result = '1;
`endif
        w_we     = 1'b1;
      end
      OP_SUB: begin
        w_flag   = w_diff[DATA_W];
        w_result = w_diff[DATA_W-1:0];
`ifdef CMD_ALU_SAT_EN
        if (w_diff[DATA_W]) w_result = '0;
`endif
        w_we     = 1'b1;
      end
      default: begin
        w_result = DATA_W'(ILLEGAL_RSP_DATA);
        w_err    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_sweep    <= '0;
      r_rsp_data <= '0;
      r_rsp_flag <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_addr  <= cmd_addr;
            r_data  <= cmd_data;
            r_state <= (cmd_op == OP_CLR) ? ST_INIT : ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_data <= w_result;
          r_rsp_flag <= w_flag;
          r_rsp_err  <= w_err;
          r_state    <= ST_RESP;
        end
        ST_INIT: begin
          if (r_sweep == {ADDR_W{1'b1}}) begin
            r_sweep    <= '0;
            r_rsp_data <= '0;
            r_rsp_flag <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_state    <= ST_RESP;
          end else begin
            r_sweep <= r_sweep + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_data  = r_rsp_data;
  assign rsp_flag  = r_rsp_flag;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_cmd_alu_engine.sv
// Directed, table-driven bench for cmd_alu_engine (default 16-bit x 16 entries).
// Expected arithmetic results follow CMD_ALU_SAT_EN when it is defined.
module tb_cmd_alu_engine;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_flag;
  logic        rsp_err;
  logic        busy;

  int passCount = 0;
  int totalCount = 0;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [15:0] expData;
    logic        expFlag;
    logic        expErr;
  } vec_t;

  vec_t vecs[19];

  cmd_alu_engine #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_flag (rsp_flag),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Issue one command, wait (bounded) for the response and complete the handshake.
  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] addr, input logic [15:0] data,
                               output logic [15:0] rData, output logic rFlag, output logic rErr,
                               output int latency);
    int waitCyc;
    @(negedge clk);
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    waitCyc = 0;
    while (!cmd_ready && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    latency = 0;
    while (!rsp_valid && latency < 100) begin
      @(posedge clk);
      #1 latency++;
    end
    checkOutput("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    rData = rsp_data;
    rFlag = rsp_flag;
    rErr  = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  logic [15:0] rd;
  logic        rf;
  logic        re;
  int          lat;
  logic [15:0] expAdd;
  logic [15:0] expSub;
  logic [15:0] expBp;
  logic [15:0] heldData;
  logic        heldFlag;

  initial begin
`ifdef CMD_ALU_SAT_EN
    expAdd = 16'hFFFF;
    expSub = 16'h0000;
    expBp  = 16'hFFFF;
`else
    expAdd = 16'h0010;
    expSub = 16'hFFFD;
    expBp  = 16'h0000;
`endif
    vecs[0]  = '{3'd1, 4'd3, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{3'd2, 4'd5, 16'h1234, 16'h1234, 1'b0, 1'b0};
    vecs[2]  = '{3'd1, 4'd5, 16'h0000, 16'h1234, 1'b0, 1'b0};
    vecs[3]  = '{3'd2, 4'd2, 16'hFFF0, 16'hFFF0, 1'b0, 1'b0};
    vecs[4]  = '{3'd3, 4'd2, 16'h0020, expAdd,   1'b1, 1'b0};
    vecs[5]  = '{3'd1, 4'd2, 16'h0000, expAdd,   1'b0, 1'b0};
    vecs[6]  = '{3'd2, 4'd7, 16'h0005, 16'h0005, 1'b0, 1'b0};
    vecs[7]  = '{3'd4, 4'd7, 16'h0008, expSub,   1'b1, 1'b0};
    vecs[8]  = '{3'd1, 4'd7, 16'h0000, expSub,   1'b0, 1'b0};
    vecs[9]  = '{3'd2, 4'd7, 16'h0005, 16'h0005, 1'b0, 1'b0};
    vecs[10] = '{3'd4, 4'd7, 16'h0001, 16'h0004, 1'b0, 1'b0};
    vecs[11] = '{3'd0, 4'd0, 16'hABCD, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{3'd2, 4'd9, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
    vecs[13] = '{3'd6, 4'd9, 16'h0001, 16'h0000, 1'b0, 1'b1};
    vecs[14] = '{3'd1, 4'd9, 16'h0000, 16'hBEEF, 1'b0, 1'b0};
    vecs[15] = '{3'd7, 4'd9, 16'h1111, 16'h0000, 1'b0, 1'b1};
    vecs[16] = '{3'd1, 4'd9, 16'h0000, 16'hBEEF, 1'b0, 1'b0};
    vecs[17] = '{3'd3, 4'd4, 16'h0003, 16'h0003, 1'b0, 1'b0};
    vecs[18] = '{3'd4, 4'd4, 16'h0003, 16'h0000, 1'b0, 1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_addr = '0;
    cmd_data = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
    checkOutput("reset_rsp_flag", {31'd0, rsp_flag}, 32'd0);
    checkOutput("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].data, rd, rf, re, lat);
      checkOutput($sformatf("vec%0d_data", i), {16'd0, rd}, {16'd0, vecs[i].expData});
      checkOutput($sformatf("vec%0d_flag", i), {31'd0, rf}, {31'd0, vecs[i].expFlag});
      checkOutput($sformatf("vec%0d_err", i), {31'd0, re}, {31'd0, vecs[i].expErr});
      checkOutput($sformatf("vec%0d_latency", i), lat, 32'd1);
    end

    // Fill every entry, then CLR must sweep for 16 cycles and zero them all.
    for (int a = 0; a < 16; a++) applyStimulus(3'd2, 4'(a), 16'hAAAA, rd, rf, re, lat);
    applyStimulus(3'd5, 4'd0, 16'h0000, rd, rf, re, lat);
    checkOutput("clr_latency", lat, 32'd16);
    checkOutput("clr_data", {16'd0, rd}, 32'd0);
    checkOutput("clr_flag", {31'd0, rf}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      applyStimulus(3'd1, 4'(a), 16'h0000, rd, rf, re, lat);
      checkOutput($sformatf("clr_read%0d", a), {16'd0, rd}, 32'd0);
    end

    // Back-pressure: response must hold while a competing command is ignored.
    applyStimulus(3'd2, 4'd1, 16'hFFFF, rd, rf, re, lat);
    @(negedge clk);
    cmd_op = 3'd3;
    cmd_addr = 4'd1;
    cmd_data = 16'h0001;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_op = 3'd2;
    cmd_data = 16'h5555;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    heldData = rsp_data;
    heldFlag = rsp_flag;
    checkOutput("bp_data", {16'd0, heldData}, {16'd0, expBp});
    checkOutput("bp_flag", {31'd0, heldFlag}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_valid%0d", c), {31'd0, rsp_valid}, 32'd1);
      checkOutput($sformatf("bp_hold_data%0d", c), {16'd0, rsp_data}, {16'd0, expBp});
      checkOutput($sformatf("bp_hold_flag%0d", c), {31'd0, rsp_flag}, 32'd1);
      checkOutput($sformatf("bp_cmd_ready%0d", c), {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    applyStimulus(3'd1, 4'd1, 16'h0000, rd, rf, re, lat);
    checkOutput("bp_ignored_cmd", {16'd0, rd}, {16'd0, expBp});

    // Reset in the middle of an INIT sweep.
    applyStimulus(3'd2, 4'd12, 16'h1111, rd, rf, re, lat);
    @(negedge clk);
    cmd_op = 3'd5;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("init_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      applyStimulus(3'd1, 4'(a), 16'h0000, rd, rf, re, lat);
      checkOutput($sformatf("midrst_read%0d", a), {16'd0, rd}, 32'd0);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
